// File: rtl/cmult_arbiter.sv
// Round-robin arbiter sharing one complex multiplier; 2-stage pipeline, 2-edge latency, 1 result/cycle.
// rsp_ready backpressure holds S2 then S1 and withholds grants; CMULT_ARB_PERF_EN adds grant/stall counters.
module cmult_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [48*NREQ-1:0] req_a,
  input  logic [48*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [47:0]       mul_a,
  output logic [47:0]       mul_b,
  input  logic [95:0]       mul_p,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [95:0]       rsp_product
`ifdef CMULT_ARB_PERF_EN
  ,
  output logic [31:0]       perf_grants,
  output logic [31:0]       perf_stalls
`endif
);

  typedef struct packed {
    logic [47:0]    a;
    logic [47:0]    b;
    logic [IDW-1:0] id;
  } s1_t;

  typedef struct packed {
    logic [95:0]    p;
    logic [IDW-1:0] id;
  } s2_t;

  s1_t            s1_q;
  s2_t            s2_q;
  logic           v1;
  logic           v2;
  logic [IDW-1:0] rr_ptr;
  logic           adv1;
  logic           adv2;
  logic           hi_found;
  logic           lo_found;
  logic [IDW-1:0] hi_id;
  logic [IDW-1:0] lo_id;
  logic [IDW-1:0] gnt_id;
  logic           gnt;
  logic [47:0]    sel_a;
  logic [47:0]    sel_b;

  assign adv2 = !v2 || rsp_ready;
  assign adv1 = !v1 || adv2;

  // Two descending scans: lowest valid index at/after rr_ptr wins, else lowest below it (wrap-around).
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (IDW'(i) >= rr_ptr)) begin
        hi_found = 1'b1;
        hi_id    = IDW'(i);
      end
      if (req_valid[i] && (IDW'(i) < rr_ptr)) begin
        lo_found = 1'b1;
        lo_id    = IDW'(i);
      end
    end
  end

  assign gnt_id = hi_found ? hi_id : lo_id;
  // Grants are suppressed while in reset even though S1 reads as empty.
  assign gnt    = rst_n && adv1 && (hi_found || lo_found);

  always_comb begin
    req_ready = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id == IDW'(i)) begin
        req_ready[i] = gnt;
        sel_a        = req_a[i*48 +: 48];
        sel_b        = req_b[i*48 +: 48];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      s1_q   <= '0;
      s2_q   <= '0;
      rr_ptr <= '0;
    end else begin
      if (adv2) begin
        v2 <= v1;
        if (v1) begin
          s2_q.p  <= mul_p;
          s2_q.id <= s1_q.id;
        end
      end
      if (adv1) begin
        v1 <= gnt;
        if (gnt) begin
          s1_q.a  <= sel_a;
          s1_q.b  <= sel_b;
          s1_q.id <= gnt_id;
        end
      end
      if (gnt) begin
        rr_ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
      end
    end
  end

  assign mul_a       = s1_q.a;
  assign mul_b       = s1_q.b;
  assign rsp_valid   = v2;
  assign rsp_id      = s2_q.id;
  assign rsp_product = s2_q.p;

`ifdef CMULT_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_grants <= '0;
      perf_stalls <= '0;
    end else begin
      if (gnt && (perf_grants != '1)) perf_grants <= perf_grants + 32'd1;
      if (v2 && !rsp_ready && (perf_stalls != '1)) perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule
